// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that shares one register-bank write port between NREQ requesters.
// Each grant produces one isolated single-cycle write strobe followed by RECOVERY idle cycles.
module reg_write_arbiter #(
   parameter int unsigned NREQ     = 4,
   parameter int unsigned AW       = 8,
   parameter int unsigned DW       = 32,
   parameter int unsigned RECOVERY = 1,
   localparam int unsigned IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]   ack,
   output logic              wr_en,
   output logic [AW-1:0]     wr_addr,
   output logic [DW-1:0]     wr_data,
   output logic [IDW-1:0]    wr_id,
   output logic              busy
);

   localparam int unsigned SW = IDW + 1;

   typedef enum logic [1:0] {StIdle, StWrite, StRecover} state_e;

   state_e            state_q, state_d;
   logic [IDW-1:0]    last_q, last_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [NREQ-1:0]   ack_q, ack_d;
   logic              wr_en_q, wr_en_d;
   logic [AW-1:0]     wr_addr_q, wr_addr_d;
   logic [DW-1:0]     wr_data_q, wr_data_d;
   logic [IDW-1:0]    wr_id_q, wr_id_d;
   logic              busy_q, busy_d;

   logic [AW-1:0]     addr_arr [NREQ];
   logic [DW-1:0]     data_arr [NREQ];
   logic              found;
   logic [IDW-1:0]    grant;
   logic [SW-1:0]     rr_idx;

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign addr_arr[i] = req_addr[i*AW +: AW];
      assign data_arr[i] = req_data[i*DW +: DW];
   end

   // Scan from last+1 upward with wrap; the first hit wins.
   always_comb begin
      found  = 1'b0;
      grant  = last_q;
      rr_idx = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         rr_idx = {1'b0, last_q} + SW'(k);
         if (rr_idx >= SW'(NREQ)) rr_idx = rr_idx - SW'(NREQ);
         if (!found && req[rr_idx[IDW-1:0]]) begin
            found = 1'b1;
            grant = rr_idx[IDW-1:0];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      ack_d     = '0;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      wr_id_d   = wr_id_q;
      busy_d    = busy_q;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               state_d      = StWrite;
               last_d       = grant;
               wr_id_d      = grant;
               wr_addr_d    = addr_arr[grant];
               wr_data_d    = data_arr[grant];
               wr_en_d      = 1'b1;
               ack_d[grant] = 1'b1;
               busy_d       = 1'b1;
            end
         end
         StWrite: begin
            if (RECOVERY > 0) begin
               state_d = StRecover;
               cnt_d   = 4'(RECOVERY - 1);
               busy_d  = 1'b1;
            end else begin
               state_d = StIdle;
               busy_d  = 1'b0;
            end
         end
         StRecover: begin
            if (cnt_q == 4'd0) begin
               state_d = StIdle;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         last_q    <= IDW'(NREQ - 1);
         cnt_q     <= '0;
         ack_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_id_q   <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         ack_q     <= ack_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         wr_id_q   <= wr_id_d;
         busy_q    <= busy_d;
      end
   end

   assign ack     = ack_q;
   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign wr_id   = wr_id_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: one instance with RECOVERY=1 for arbitration tests,
// plus RECOVERY=0 and RECOVERY=3 instances sharing a request line for write-period tests.
module tb_reg_write_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [3:0]   req_a = '0;
   logic [31:0]  addr_a = {8'h7F, 8'h10, 8'h21, 8'h20};
   logic [127:0] data_a = {32'hCAFE0003, 32'hDEADBEEF, 32'hCAFE0001, 32'hCAFE0000};
   logic [3:0]   ack_a;
   logic         wr_en_a, busy_a;
   logic [7:0]   wr_addr_a;
   logic [31:0]  wr_data_a;
   logic [1:0]   wr_id_a;

   logic [3:0]   req_b = '0;
   logic [3:0]   ack_r0, ack_r3;
   logic         wr_en_r0, wr_en_r3, busy_r0, busy_r3;
   logic [7:0]   wr_addr_r0, wr_addr_r3;
   logic [31:0]  wr_data_r0, wr_data_r3;
   logic [1:0]   wr_id_r0, wr_id_r3;

   reg_write_arbiter #(.NREQ(4), .AW(8), .DW(32), .RECOVERY(1)) dut (
      .clk(clk), .rst(rst), .req(req_a), .req_addr(addr_a), .req_data(data_a),
      .ack(ack_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
      .wr_id(wr_id_a), .busy(busy_a)
   );

   reg_write_arbiter #(.NREQ(4), .AW(8), .DW(32), .RECOVERY(0)) dut_r0 (
      .clk(clk), .rst(rst), .req(req_b), .req_addr(addr_a), .req_data(data_a),
      .ack(ack_r0), .wr_en(wr_en_r0), .wr_addr(wr_addr_r0), .wr_data(wr_data_r0),
      .wr_id(wr_id_r0), .busy(busy_r0)
   );

   reg_write_arbiter #(.NREQ(4), .AW(8), .DW(32), .RECOVERY(3)) dut_r3 (
      .clk(clk), .rst(rst), .req(req_b), .req_addr(addr_a), .req_data(data_a),
      .ack(ack_r3), .wr_en(wr_en_r3), .wr_addr(wr_addr_r3), .wr_data(wr_data_r3),
      .wr_id(wr_id_r3), .busy(busy_r3)
   );

   int checks = 0;
   int failures = 0;

   int         got_n;
   int         got_id [16];
   int         got_t [16];
   logic [3:0] got_ack [16];
   logic [7:0] got_addr [16];

   function automatic logic [7:0] exp_addr(input int i);
      case (i)
         0: return 8'h20;
         1: return 8'h21;
         2: return 8'h10;
         default: return 8'h7F;
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   // Record each write seen on the main instance; optionally drop the acked request.
   task automatic collect(input int n, input int limit, input bit drop);
      int cyc = 0;
      got_n = 0;
      while (got_n < n && cyc < limit) begin
         step();
         cyc++;
         if (wr_en_a) begin
            got_id[got_n]   = int'(wr_id_a);
            got_t[got_n]    = cyc;
            got_ack[got_n]  = ack_a;
            got_addr[got_n] = wr_addr_a;
            got_n++;
            if (drop) req_a = req_a & ~ack_a;
         end
      end
      check("write_count", 64'(got_n), 64'(n));
   endtask

   task automatic check_grants(input string tag, input int exp_ids [16], input int n);
      for (int k = 0; k < n && k < got_n; k++) begin
         check({tag, "_id"}, 64'(got_id[k]), 64'(exp_ids[k]));
         check({tag, "_ack"}, 64'(got_ack[k]), 64'(4'b0001 << exp_ids[k]));
         check({tag, "_addr"}, 64'(got_addr[k]), 64'(exp_addr(exp_ids[k])));
      end
   endtask

   initial begin
      int exp_ids [16];
      int t0 [4];
      int t3 [4];
      int n0, n3, cnt;

      // Reset state
      step();
      check("rst_wr_en", 64'(wr_en_a), 64'd0);
      check("rst_ack", 64'(ack_a), 64'd0);
      check("rst_busy", 64'(busy_a), 64'd0);
      check("rst_addr_data_id", {wr_addr_a, wr_data_a, 6'd0, wr_id_a}, 64'd0);
      rst = 1'b0;

      // Single requester
      req_a = 4'b0100;
      step();
      req_a = 4'b0000;
      check("single_wr_en", 64'(wr_en_a), 64'd1);
      check("single_addr", 64'(wr_addr_a), 64'h10);
      check("single_data", 64'(wr_data_a), 64'hDEADBEEF);
      check("single_id", 64'(wr_id_a), 64'd2);
      check("single_ack", 64'(ack_a), 64'b0100);
      check("single_busy1", 64'(busy_a), 64'd1);
      step();
      check("single_rec_wr_en", 64'(wr_en_a), 64'd0);
      check("single_rec_ack", 64'(ack_a), 64'd0);
      check("single_busy2", 64'(busy_a), 64'd1);
      step();
      check("single_busy_end", 64'(busy_a), 64'd0);

      // Simultaneous requests from reset: 0,1,3 spaced 3 cycles
      do_reset();
      req_a = 4'b1011;
      collect(3, 20, 1'b1);
      exp_ids[0] = 0; exp_ids[1] = 1; exp_ids[2] = 3;
      check_grants("simul", exp_ids, 3);
      check("simul_latency", 64'(got_t[0]), 64'd1);
      check("simul_gap1", 64'(got_t[1] - got_t[0]), 64'd3);
      check("simul_gap2", 64'(got_t[2] - got_t[1]), 64'd3);
      req_a = 4'b0000;

      // Fairness with all requesters held
      do_reset();
      req_a = 4'b1111;
      collect(12, 60, 1'b0);
      req_a = 4'b0000;
      for (int k = 0; k < 12; k++) exp_ids[k] = k % 4;
      check_grants("fair", exp_ids, 12);

      // Write period for RECOVERY=0 and RECOVERY=3
      do_reset();
      req_b = 4'b0001;
      n0 = 0;
      n3 = 0;
      for (int c = 1; c <= 25; c++) begin
         step();
         if (wr_en_r0 && n0 < 4) begin t0[n0] = c; n0++; end
         if (wr_en_r3 && n3 < 4) begin t3[n3] = c; n3++; end
      end
      req_b = 4'b0000;
      check("r0_count", 64'(n0), 64'd4);
      check("r3_count", 64'(n3), 64'd4);
      check("r0_first", 64'(t0[0]), 64'd1);
      check("r3_first", 64'(t3[0]), 64'd1);
      for (int k = 1; k < 4; k++) begin
         check("r0_period", 64'(t0[k] - t0[k-1]), 64'd2);
         check("r3_period", 64'(t3[k] - t3[k-1]), 64'd5);
      end

      // Reset during RECOVER after a write to id 1
      do_reset();
      req_a = 4'b0010;
      step();
      req_a = 4'b0000;
      check("mid_wr_id", 64'(wr_id_a), 64'd1);
      check("mid_wr_en", 64'(wr_en_a), 64'd1);
      step();
      check("mid_recover_busy", 64'(busy_a), 64'd1);
      rst = 1'b1;
      step();
      check("mid_rst_ctl", {wr_en_a, busy_a, ack_a}, 64'd0);
      check("mid_rst_data", {wr_addr_a, wr_data_a, 6'd0, wr_id_a}, 64'd0);
      rst = 1'b0;
      req_a = 4'b0011;
      collect(2, 20, 1'b1);
      exp_ids[0] = 0; exp_ids[1] = 1;
      check_grants("mid_after", exp_ids, 2);
      req_a = 4'b0000;

      // Same again, but requests 1 and 2: a restored pointer picks 1, a stale one picks 2
      do_reset();
      req_a = 4'b0010;
      step();
      req_a = 4'b0000;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      req_a = 4'b0110;
      collect(1, 10, 1'b1);
      exp_ids[0] = 1;
      check_grants("ptr_restore", exp_ids, 1);
      req_a = 4'b0000;

      // Early drop: one-cycle pulse on requester 3
      do_reset();
      req_a = 4'b1000;
      step();
      req_a = 4'b0000;
      check("drop_wr_en", 64'(wr_en_a), 64'd1);
      check("drop_addr", 64'(wr_addr_a), 64'h7F);
      check("drop_data", 64'(wr_data_a), 64'hCAFE0003);
      check("drop_ack", 64'(ack_a), 64'b1000);
      cnt = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (wr_en_a) cnt++;
      end
      check("drop_no_second", 64'(cnt), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
